// File: rtl/sum_last4_pkg.sv
// rtl/sum_last4_pkg.sv - shared constants and FSM state type for the moving-sum encoder/decoder pair
package sum_last4_pkg;

    localparam int DATA_W     = 8;
    localparam int WIN        = 4;
    localparam int SUM_W      = DATA_W + 2;
    localparam int SAMPLE_MAX = 255;
    localparam int SUM_MAX    = 1020;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        ERR = 1'b1
    } dec_state_t;

endpackage

// File: rtl/sum_last4_hist.sv
// rtl/sum_last4_hist.sv - DEPTH-deep sample history shift register, oldest entry exposed
module sum_last4_hist #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] oldest
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (shift) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign oldest = mem[DEPTH-1];

endmodule

// File: rtl/sum_last4_dec.sv
// rtl/sum_last4_dec.sv - reconstructs samples from 4-sample window sums, flags impossible sequences
// Build option: DEC_SAT_EN clamps illegal samples and pulses err instead of locking into ERR.
module sum_last4_dec
    import sum_last4_pkg::*;
#(
    parameter  int DATA_W = sum_last4_pkg::DATA_W,
    parameter  int WIN    = sum_last4_pkg::WIN,
    localparam int SUM_W  = DATA_W + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [SUM_W-1:0]  sum_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out,
    output logic              err
);

    if (WIN != 4) begin : g_win_check
        $error("sum_last4_dec: WIN must be 4");
    end

    dec_state_t              state;
    logic [SUM_W-1:0]        s_prev;
    logic [DATA_W-1:0]       hist_old;
    logic [DATA_W-1:0]       d_sample;
    logic signed [SUM_W+1:0] d;
    logic                    d_neg;
    logic                    d_legal;
    logic                    accept;

    // x[n] = S[n] - S[n-1] + x[n-4]; two guard bits keep the signed result exact
    assign d = $signed({2'b00, sum_in}) - $signed({2'b00, s_prev})
             + $signed({{(SUM_W + 2 - DATA_W){1'b0}}, hist_old});

    assign d_neg   = d[SUM_W+1];
    assign d_legal = !d_neg && (d[SUM_W:DATA_W] == '0);

`ifdef DEC_SAT_EN
    assign d_sample = d_legal ? d[DATA_W-1:0] : (d_neg ? '0 : '1);
    assign accept   = (state == RUN) && in_valid;
`else
    assign d_sample = d[DATA_W-1:0];
    assign accept   = (state == RUN) && in_valid && d_legal;
`endif

    sum_last4_hist #(
        .DATA_W (DATA_W),
        .DEPTH  (WIN)
    ) u_hist (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .shift  (accept),
        .din    (d_sample),
        .oldest (hist_old)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            s_prev    <= '0;
        end else if (clr) begin
            state     <= RUN;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            s_prev    <= '0;
        end else begin
            case (state)
                RUN: begin
                    out_valid <= 1'b0;
`ifdef DEC_SAT_EN
                    err       <= 1'b0;
`endif
                    if (in_valid) begin
                        if (accept) begin
                            out       <= d_sample;
                            out_valid <= 1'b1;
                            s_prev    <= sum_in;
`ifdef DEC_SAT_EN
                            err       <= !d_legal;
`endif
                        end else begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                ERR: begin
                    out_valid <= 1'b0;
                    err       <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_last4_dec.sv
// tb/tb_sum_last4_dec.sv - scoreboard bench for sum_last4_dec with window-sum reference model
module tb_sum_last4_dec;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       in_valid;
    logic [9:0] sum_in;
    logic       out_valid;
    logic [7:0] out;
    logic       err;

    sum_last4_dec dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out       (out),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] o;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model: decoded samples newest-first, sticky error, last output, last accepted sum
    int hq[$];
    bit m_err;
    int m_out;
    int m_sprev;

    function automatic void model_reset();
        hq      = '{0, 0, 0, 0};
        m_err   = 1'b0;
        m_out   = 0;
        m_sprev = 0;
    endfunction

    function automatic exp_t model_step(bit v, int s, bit c);
        exp_t r;
        int   d;
        if (c) begin
            model_reset();
            r = '{1'b0, 8'd0, 1'b0};
            return r;
        end
        if (m_err || !v) begin
            r = '{1'b0, m_out[7:0], m_err};
            return r;
        end
`ifdef DEC_SAT_EN
        d = s - m_sprev + hq[3];
        if (d >= 0 && d <= 255) begin
            r = '{1'b1, d[7:0], 1'b0};
        end else begin
            d = (d < 0) ? 0 : 255;
            r = '{1'b1, d[7:0], 1'b1};
        end
`else
        d = s - (hq[0] + hq[1] + hq[2]);
        if (d < 0 || d > 255) begin
            m_err = 1'b1;
            r = '{1'b0, m_out[7:0], 1'b1};
            return r;
        end
        r = '{1'b1, d[7:0], 1'b0};
`endif
        hq.push_front(d);
        void'(hq.pop_back());
        m_out   = d;
        m_sprev = s;
        return r;
    endfunction

    task automatic check(string name, int act, int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    task automatic drive(bit v, int s, bit c);
        @(negedge clk);
        #1;
        in_valid = v;
        sum_in   = s[9:0];
        clr      = c;
        exp_q.push_back(model_step(v, s, c));
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
        reset    = 1'b0;
        #2;
        check("async_rst_out", out, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_err", err, 0);
        #1;
        reset = 1'b1;
        model_reset();
        exp_q.push_back('{1'b0, 8'd0, 1'b0});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid", out_valid, e.v);
                check("out", out, e.o);
                check("err", err, e.e);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int seq1[6] = '{100, 200, 200, 250, 200, 350};
        int seq2[8] = '{255, 510, 765, 1020, 765, 510, 255, 0};
        int xs[$];
        int s;
        int wait_cnt;

        reset    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        sum_in   = '0;
        model_reset();
        #12;
        check("reset_out", out, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_err", err, 0);
        #2;
        reset = 1'b1;

        foreach (seq1[i]) drive(1'b1, seq1[i], 1'b0);
        drive(1'b0, 0, 1'b1);
        foreach (seq2[i]) drive(1'b1, seq2[i], 1'b0);

        // out-of-range sum locks error; clr recovers
        async_reset_pulse();
        drive(1'b1, 300, 1'b0);
        drive(1'b1, 10, 1'b0);
        drive(1'b1, 20, 1'b0);
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 10, 1'b0);

        // negative sample
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 100, 1'b0);
        drive(1'b1, 50, 1'b0);
        drive(1'b1, 50, 1'b0);

        // gaps in in_valid
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 10, 1'b0);
        repeat (3) drive(1'b0, 0, 1'b0);
        drive(1'b1, 11, 1'b0);

        // asynchronous reset mid-stream
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 100, 1'b0);
        drive(1'b1, 200, 1'b0);
        async_reset_pulse();
        drive(1'b1, 20, 1'b0);

        // randomized rounds: encoder-generated sums with gaps, then a random possibly-corrupt sum
        for (int round = 0; round < 6; round++) begin
            drive(1'b0, 0, 1'b1);
            xs = '{0, 0, 0};
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    drive(1'b0, $urandom_range(0, 1023), 1'b0);
                end else begin
                    xs.push_front($urandom_range(0, 255));
                    s = xs[0] + xs[1] + xs[2] + xs[3];
                    void'(xs.pop_back());
                    drive(1'b1, s, 1'b0);
                end
            end
            drive(1'b1, $urandom_range(0, 1023), 1'b0);
            repeat (3) drive(1'b1, $urandom_range(0, 1023), 1'b0);
        end

        drive(1'b0, 0, 1'b0);
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
